// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants, bank type and FSM encoding for the FIR coefficient loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_coeff_loader_pkg;

  localparam int NTAP    = 12;
  localparam int COEFF_W = 16;
  localparam int GAIN_W  = 20;
  localparam int ADDR_W  = 4;

  localparam logic [COEFF_W-1:0] DEFAULT_C0 = 16'h2000;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef coeff_t [NTAP-1:0]  bank_t;

  // Pass-through filter: unity on tap 0, everything else zero.
  localparam bank_t DEFAULT_BANK = bank_t'({{((NTAP-1)*COEFF_W){1'b0}}, DEFAULT_C0});

  // Gain of the default bank, which is also the gain reported out of reset.
  localparam logic [GAIN_W-1:0] DEFAULT_GAIN =
    {{(GAIN_W-COEFF_W){DEFAULT_C0[COEFF_W-1]}}, DEFAULT_C0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SUM   = 2'd2
  } state_t;

  function automatic logic [GAIN_W-1:0] sext_coeff(input coeff_t c);
    return {{(GAIN_W-COEFF_W){c[COEFF_W-1]}}, c};
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(NTAP);
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Control-bus bundle: coefficient writes, commit/sync controls, readback.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is taken in the cycle it is presented.
interface fir_coeff_loader_if;
  import fir_coeff_loader_pkg::*;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COEFF_W-1:0] wr_data;
  logic               load_default;
  logic               commit;
  logic               sync;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_bank;
  logic [COEFF_W-1:0] rd_data;
  logic               addr_err;

  modport master (
    output wr_en, wr_addr, wr_data, load_default, commit, sync, rd_addr, rd_bank,
    input  rd_data, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, load_default, commit, sync, rd_addr, rd_bank,
    output rd_data, addr_err
  );

endinterface

// File: rtl/fir_gain_acc.sv
// Serial DC-gain accumulator: sums the NTAP active taps one per cycle.
// Latency: NTAP accumulate edges plus one result edge after i_start.
// Backpressure: none; runs while i_en is held, o_done marks the result edge.
module fir_gain_acc
  import fir_coeff_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_en,
  input  bank_t             i_taps,
  output logic              o_done,
  output logic [GAIN_W-1:0] o_gain_sum,
  output logic              o_gain_vld
);

  logic [ADDR_W-1:0] r_cnt;
  logic [GAIN_W-1:0] r_acc;
  logic              w_cnt_end;

  // Counter past the last tap means the sum is complete.
  always_comb begin
    w_cnt_end = (r_cnt == ADDR_W'(NTAP));
    o_done    = i_en && w_cnt_end;
  end

  // Accumulate one sign-extended tap per edge, then publish the total.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      o_gain_sum <= DEFAULT_GAIN;
      o_gain_vld <= 1'b0;
    end else begin
      o_gain_vld <= 1'b0;
      if (i_start) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (i_en) begin
        if (!w_cnt_end) begin
          r_acc <= r_acc + sext_coeff(i_taps[r_cnt]);
          r_cnt <= r_cnt + 1'b1;
        end else begin
          o_gain_sum <= r_acc;
          o_gain_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Shadow/active coefficient banks with sync-aligned atomic commit and DC-gain check.
// Latency: readback and address error 1 cycle; gain ready 13 edges after transfer.
// Backpressure: none; writes always land, commit/sync ignored while busy.
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  fir_coeff_loader_if.slave   io_cfg,
  output logic                o_busy,
  output logic [GAIN_W-1:0]   o_gain_sum,
  output logic                o_gain_vld,
  output logic [COEFF_W-1:0]  o_coeff_0,
  output logic [COEFF_W-1:0]  o_coeff_1,
  output logic [COEFF_W-1:0]  o_coeff_2,
  output logic [COEFF_W-1:0]  o_coeff_3,
  output logic [COEFF_W-1:0]  o_coeff_4,
  output logic [COEFF_W-1:0]  o_coeff_5,
  output logic [COEFF_W-1:0]  o_coeff_6,
  output logic [COEFF_W-1:0]  o_coeff_7,
  output logic [COEFF_W-1:0]  o_coeff_8,
  output logic [COEFF_W-1:0]  o_coeff_9,
  output logic [COEFF_W-1:0]  o_coeff_10,
  output logic [COEFF_W-1:0]  o_coeff_11
);

  state_t             r_state;
  state_t             w_next;
  bank_t              r_shadow;
  bank_t              r_active;
  bank_t              w_rd_bank;
  logic [COEFF_W-1:0] r_rd_data;
  logic               r_addr_err;
  logic               w_transfer;
  logic               w_sum_en;
  logic               w_sum_done;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and per-state strobes; sync in IDLE is deliberately dropped.
  always_comb begin
    w_next     = r_state;
    w_transfer = 1'b0;
    w_sum_en   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_cfg.commit) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (io_cfg.sync) begin
          w_transfer = 1'b1;
          w_next     = ST_SUM;
        end
      end
      ST_SUM: begin
        w_sum_en = 1'b1;
        if (w_sum_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shadow bank: load-default only in IDLE and overrides a same-cycle write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= DEFAULT_BANK;
    end else if (io_cfg.load_default && (r_state == ST_IDLE)) begin
      r_shadow <= DEFAULT_BANK;
    end else if (io_cfg.wr_en && addr_ok(io_cfg.wr_addr)) begin
      r_shadow[io_cfg.wr_addr] <= io_cfg.wr_data;
    end
  end

  // Active bank: whole-bank copy on the transfer edge, using pre-edge shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_active <= DEFAULT_BANK;
    else if (w_transfer) r_active <= r_shadow;
  end

  // Readback mux and out-of-range write flag, both registered.
  always_comb w_rd_bank = io_cfg.rd_bank ? r_active : r_shadow;

  // Registered readback and address-error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_data  <= addr_ok(io_cfg.rd_addr) ? w_rd_bank[io_cfg.rd_addr] : '0;
      r_addr_err <= io_cfg.wr_en && !addr_ok(io_cfg.wr_addr);
    end
  end

  fir_gain_acc u_gain_acc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_transfer),
    .i_en       (w_sum_en),
    .i_taps     (r_active),
    .o_done     (w_sum_done),
    .o_gain_sum (o_gain_sum),
    .o_gain_vld (o_gain_vld)
  );

  assign io_cfg.rd_data  = r_rd_data;
  assign io_cfg.addr_err = r_addr_err;
  assign o_busy          = (r_state != ST_IDLE);

  assign o_coeff_0  = r_active[0];
  assign o_coeff_1  = r_active[1];
  assign o_coeff_2  = r_active[2];
  assign o_coeff_3  = r_active[3];
  assign o_coeff_4  = r_active[4];
  assign o_coeff_5  = r_active[5];
  assign o_coeff_6  = r_active[6];
  assign o_coeff_7  = r_active[7];
  assign o_coeff_8  = r_active[8];
  assign o_coeff_9  = r_active[9];
  assign o_coeff_10 = r_active[10];
  assign o_coeff_11 = r_active[11];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with readback and gain scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_coeff_loader;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [19:0] gain_sum;
  logic        gain_vld;
  logic [11:0][15:0] coeff;

  int n_asserts;
  int n_fail;
  int n_vld_pulses;

  logic [15:0] rd_q[$];
  logic [19:0] gain_q[$];

  fir_coeff_loader_if cfg ();

  fir_coeff_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .io_cfg     (cfg),
    .o_busy     (busy),
    .o_gain_sum (gain_sum),
    .o_gain_vld (gain_vld),
    .o_coeff_0  (coeff[0]),
    .o_coeff_1  (coeff[1]),
    .o_coeff_2  (coeff[2]),
    .o_coeff_3  (coeff[3]),
    .o_coeff_4  (coeff[4]),
    .o_coeff_5  (coeff[5]),
    .o_coeff_6  (coeff[6]),
    .o_coeff_7  (coeff[7]),
    .o_coeff_8  (coeff[8]),
    .o_coeff_9  (coeff[9]),
    .o_coeff_10 (coeff[10]),
    .o_coeff_11 (coeff[11])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every gain-valid pulse, sampled on the inactive edge.
  always @(negedge clk) if (gain_vld === 1'b1) n_vld_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg.wr_en   = 1'b1;
    cfg.wr_addr = a;
    cfg.wr_data = d;
    tick();
    cfg.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic bank, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] e;
    cfg.rd_bank = bank;
    cfg.rd_addr = a;
    rd_q.push_back(exp);
    tick();
    e = rd_q.pop_front();
    check($sformatf("rd bank%0d[%0d]", bank, a), {16'h0, cfg.rd_data}, {16'h0, e});
  endtask

  task automatic check_active(input string tag, input logic [11:0][15:0] exp);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s coeff_%0d", tag, i), {16'h0, coeff[i]}, {16'h0, exp[i]});
  endtask

  // Called right after the transfer edge; waits for the gain pulse and scores it.
  task automatic wait_gain(input string tag);
    int n;
    logic [19:0] e;
    n = 0;
    while (gain_vld !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " gain latency"}, n, 13);
    e = (gain_q.size() > 0) ? gain_q.pop_front() : 20'hx;
    check({tag, " gain_sum"}, {12'h0, gain_sum}, {12'h0, e});
    check({tag, " busy low"}, {31'h0, busy}, 0);
    tick();
    check({tag, " gain_vld one cycle"}, {31'h0, gain_vld}, 0);
  endtask

  task automatic commit_then_sync(input logic [19:0] exp_gain);
    cfg.commit = 1'b1;
    tick();
    cfg.commit = 1'b0;
    check("busy after commit", {31'h0, busy}, 1);
    cfg.sync = 1'b1;
    gain_q.push_back(exp_gain);
    tick();
    cfg.sync = 1'b0;
  endtask

  logic [11:0][15:0] exp_act;
  logic [11:0][15:0] dflt;

  initial begin
    n_asserts = 0; n_fail = 0; n_vld_pulses = 0;
    dflt = '0;
    dflt[0] = 16'h2000;
    cfg.wr_en = 0; cfg.wr_addr = 0; cfg.wr_data = 0; cfg.load_default = 0;
    cfg.commit = 0; cfg.sync = 0; cfg.rd_addr = 0; cfg.rd_bank = 0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check_active("reset", dflt);
    check("reset gain_sum", {12'h0, gain_sum}, 32'h02000);
    check("reset busy", {31'h0, busy}, 0);
    check("reset gain_vld", {31'h0, gain_vld}, 0);
    check("reset rd_data", {16'h0, cfg.rd_data}, 0);
    check("reset addr_err", {31'h0, cfg.addr_err}, 0);
    rst_n = 1'b1;
    tick();
    rd(1'b1, 4'd0, 16'h2000);
    rd(1'b0, 4'd0, 16'h2000);
    rd(1'b1, 4'd5, 16'h0000);

    // All taps 0x02AB, sync five cycles after commit
    for (int i = 0; i < 12; i++) wr(4'(i), 16'h02AB);
    rd(1'b0, 4'd11, 16'h02AB);
    cfg.commit = 1'b1;
    tick();
    cfg.commit = 1'b0;
    check("busy after commit", {31'h0, busy}, 1);
    repeat (4) tick();
    check_active("pre-sync", dflt);
    cfg.sync = 1'b1;
    gain_q.push_back(20'h02004);
    tick();
    cfg.sync = 1'b0;
    for (int i = 0; i < 12; i++) exp_act[i] = 16'h02AB;
    check_active("post-sync", exp_act);
    wait_gain("02AB");

    // All taps -4096
    for (int i = 0; i < 12; i++) wr(4'(i), 16'hF000);
    commit_then_sync(20'hF4000);
    for (int i = 0; i < 12; i++) exp_act[i] = 16'hF000;
    check_active("F000", exp_act);
    wait_gain("F000");

    // Out-of-range write
    wr(4'd13, 16'h1234);
    check("addr_err pulse", {31'h0, cfg.addr_err}, 1);
    tick();
    check("addr_err clears", {31'h0, cfg.addr_err}, 0);
    rd(1'b0, 4'd13, 16'h0000);
    rd(1'b0, 4'd1, 16'hF000);
    rd(1'b1, 4'd1, 16'hF000);
    check_active("after bad addr", exp_act);

    // Commit and sync together only arms; next sync transfers
    wr(4'd0, 16'h1000);
    cfg.commit = 1'b1;
    cfg.sync   = 1'b1;
    tick();
    cfg.commit = 1'b0;
    cfg.sync   = 1'b0;
    check("busy armed", {31'h0, busy}, 1);
    check("no early transfer", {16'h0, coeff[0]}, 32'hF000);
    tick();
    check("still armed", {16'h0, coeff[0]}, 32'hF000);
    // Write to tap 3 on the transfer edge stays in shadow only
    cfg.sync    = 1'b1;
    cfg.wr_en   = 1'b1;
    cfg.wr_addr = 4'd3;
    cfg.wr_data = 16'h0777;
    gain_q.push_back(20'hF6000);
    tick();
    cfg.sync  = 1'b0;
    cfg.wr_en = 1'b0;
    exp_act[0] = 16'h1000;
    check_active("sync xfer", exp_act);
    wait_gain("xfer");
    rd(1'b0, 4'd3, 16'h0777);
    rd(1'b1, 4'd3, 16'hF000);

    // Back-to-back commit, load-default while busy, then reset mid-sum
    cfg.commit = 1'b1;
    tick();
    cfg.commit = 1'b0;
    check("b2b commit accepted", {31'h0, busy}, 1);
    cfg.sync = 1'b1;
    tick();
    cfg.sync = 1'b0;
    exp_act[3] = 16'h0777;
    check_active("b2b xfer", exp_act);
    cfg.load_default = 1'b1;
    tick();
    cfg.load_default = 1'b0;
    rd(1'b0, 4'd0, 16'h1000);
    rd(1'b0, 4'd3, 16'h0777);
    check("busy in sum", {31'h0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'h0, busy}, 0);
    check("abort gain_sum", {12'h0, gain_sum}, 32'h02000);
    check_active("abort", dflt);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("gain pulses total", n_vld_pulses, 3);
    rd(1'b0, 4'd3, 16'h0000);
    rd(1'b0, 4'd0, 16'h2000);

    // Load-default in IDLE beats a same-cycle write
    wr(4'd5, 16'h0101);
    rd(1'b0, 4'd5, 16'h0101);
    cfg.load_default = 1'b1;
    cfg.wr_en   = 1'b1;
    cfg.wr_addr = 4'd7;
    cfg.wr_data = 16'h0202;
    tick();
    cfg.load_default = 1'b0;
    cfg.wr_en = 1'b0;
    rd(1'b0, 4'd5, 16'h0000);
    rd(1'b0, 4'd7, 16'h0000);
    rd(1'b0, 4'd0, 16'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Configuration-side writer for the 12-tap FIR datapath. Accepts single-word coefficient writes from the board control bus into a shadow bank, then transfers the shadow bank into the active bank atomically on a sample-frame sync after a commit request. Drives COEFF_0..COEFF_11 to the FIR. After each transfer it computes the DC gain (sum of active coefficients) so firmware can confirm unity gain (0x2000, coefficients scaled by 2^13).

## Interface
- COEFF_W, 16: coefficient width, two's complement, scale 2^13
- NTAP, 12: number of taps, fixed; addresses 0..NTAP-1 valid
- DEFAULT_C0, 16'h2000: reset/default value of tap 0; all other taps default 0 (pass-through filter)

- CLK  in  1  single clock; all logic on posedge
- RSTn  in  1  asynchronous, active-low reset
- WR_EN  in  1  write strobe, one word per cycle
- WR_ADDR  in  4  shadow tap index
- WR_DATA  in  16  coefficient value
- LOAD_DEFAULT  in  1  load default set into shadow bank
- COMMIT  in  1  request shadow→active transfer
- SYNC  in  1  frame/sample boundary pulse; transfer point
- RD_ADDR  in  4  readback tap index
- RD_BANK  in  1  0 = shadow, 1 = active
- RD_DATA  out  16  registered readback
- ADDR_ERR  out  1  one-cycle pulse, write to address > 11
- BUSY  out  1  commit armed or gain sum in progress
- GAIN_SUM  out  20  signed sum of active coefficients
- GAIN_VALID  out  1  one-cycle pulse when GAIN_SUM updates
- COEFF_0 … COEFF_11  out  16 each  active bank, registered

## Operation
- Reset: shadow and active banks = defaults; GAIN_SUM = 20'h02000; RD_DATA 0; ADDR_ERR, BUSY, GAIN_VALID 0; state IDLE.
- Writes: WR_EN with WR_ADDR ≤ 11 updates shadow[WR_ADDR] at the edge; accepted in every state. WR_ADDR 12..15: no write, ADDR_ERR high for the following cycle.
- LOAD_DEFAULT: honoured in IDLE only, shadow ← defaults in one edge; wins over a same-cycle WR_EN. Ignored (no effect) when BUSY.
- FSM states IDLE, ARMED, SUM.
  - IDLE: COMMIT → ARMED. SYNC alone ignored. COMMIT and SYNC in the same cycle → ARMED only; transfer waits for the next SYNC.
  - ARMED: SYNC → active ← shadow (all 12 taps, same edge), accumulator cleared, tap counter 0 → SUM. COMMIT ignored.
  - SUM: 12 cycles; each edge adds sign-extended active[counter] to a 20-bit accumulator, counter 0..11. The edge after counter 11 loads GAIN_SUM, pulses GAIN_VALID, returns to IDLE. COMMIT and SYNC ignored.
- Transfer captures shadow as it was before the transfer edge: a write coinciding with the transfer edge lands in shadow only and is not part of that commit.
- BUSY = state ≠ IDLE (registered with state).
- Readback: RD_DATA ← selected bank[RD_ADDR] one cycle later; RD_ADDR > 11 returns 0.
- Arithmetic: 12 × 16-bit signed fits 20 bits, no overflow possible; no saturation.
- Reset mid-operation: immediate return to reset values; an armed commit or a partial sum is discarded.

## Timing
- COMMIT sampled at edge C → BUSY high after C.
- SYNC sampled at edge E0 in ARMED → COEFF_* show new values after E0; all taps change on the same edge.
- Accumulate edges E1..E12; GAIN_SUM update and GAIN_VALID high after E13; BUSY low after E13.
- Back-to-back: a new COMMIT is accepted on the first cycle with BUSY low.
- RD_DATA latency 1 cycle; ADDR_ERR latency 1 cycle.

## Structure
- Shared package: NTAP, COEFF_W, GAIN_W (20), default-bank constant, FSM state encoding.
- Banks as 12-entry register arrays; COEFF_* outputs are flat wires of the active array.
- Optional sub-module fir_gain_acc (counter + accumulator, start/done); otherwise a single module.

## Test plan
- Reset → COEFF_0 = 0x2000, COEFF_1..11 = 0, GAIN_SUM = 0x02000, BUSY 0; RD_BANK=1, RD_ADDR=0 → RD_DATA 0x2000.
- Write taps 0..11 = 0x02AB each, COMMIT, SYNC 5 cycles later → COEFF_* unchanged until the SYNC edge, then all 0x02AB on one edge; GAIN_VALID 13 cycles later with GAIN_SUM = 0x02004.
- Write taps with 0xF000 (−4096) on all 12 taps, commit/sync → GAIN_SUM = 20'hF4000 (−49152).
- WR_ADDR = 13 → ADDR_ERR pulse, shadow and active unchanged (readback of both banks).
- COMMIT and SYNC together in IDLE → no transfer; next SYNC transfers. Write to tap 3 on the transfer edge → active[3] keeps its old value, shadow[3] holds the new value.
- Assert RSTn low during SUM → BUSY 0, banks default, GAIN_VALID never pulses for the aborted sum; LOAD_DEFAULT while BUSY → shadow unchanged.
